// File: rtl/shift_seq_pkg.sv
// rtl/shift_seq_pkg.sv - shared types and fill-source helper for the shift sequencer
package shift_seq_pkg;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam logic [1:0] FILL_ZERO = 2'b00;
    localparam logic [1:0] FILL_ONE  = 2'b01;
    localparam logic [1:0] FILL_ROT  = 2'b10;
    localparam logic [1:0] FILL_SER  = 2'b11;

    // Rotate takes the bit leaving the register: MSB when shifting up, LSB when shifting down.
    function automatic logic fill_bit(input logic [1:0] fill,
                                      input logic       dir,
                                      input logic       msb,
                                      input logic       lsb,
                                      input logic       sin);
        logic b;
        case (fill)
            FILL_ZERO: b = 1'b0;
            FILL_ONE:  b = 1'b1;
            FILL_ROT:  b = dir ? lsb : msb;
            default:   b = sin;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/shift_seq_cnt.sv
// rtl/shift_seq_cnt.sv - loadable down-counter that stops at one
module shift_seq_cnt #(
    parameter int CW = 3
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    input  logic          dec_i,
    output logic [CW-1:0] cnt_o,
    output logic          is_one_o
);

    localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Load has priority; decrement is held off at one so the count can never wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q > ONE)) begin
            cnt_d = cnt_q - ONE;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign is_one_o = (cnt_q == ONE);

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - load-and-shift command controller for an external shift register
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int W  = 4,
    parameter int CW = $clog2(W) + 1
) (
    input  logic          clk_i,
    input  logic          res_ni,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic [W-1:0]  din_i,
    input  logic [CW-1:0] amt_i,
    input  logic          dir_i,
    input  logic [1:0]    fill_i,
    input  logic          sin_i,
    input  logic [W-1:0]  sr_q_i,
    output logic          sr_clr_o,
    output logic          sr_pen_o,
    output logic          sr_len_o,
    output logic          sr_inr_o,
    output logic          sr_inl_o,
    output logic [W-1:0]  sr_din_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          sout_o,
    output logic          sout_vld_o
);

    state_e        state_q;
    state_e        state_d;
    logic [W-1:0]  din_q;
    logic [W-1:0]  din_d;
    logic          dir_q;
    logic          dir_d;
    logic [1:0]    fill_q;
    logic [1:0]    fill_d;
    logic          accept;
    logic          cnt_dec;
    logic [CW-1:0] cnt;
    logic          cnt_is_one;
    logic          fill;
    logic          out_bit;

    // A command is taken only from IDLE, and an abort in the same cycle wins.
    assign accept  = (state_q == ST_IDLE) && start_i && !abort_i;
    assign cnt_dec = (state_q == ST_SHIFT);

    shift_seq_cnt #(
        .CW(CW)
    ) u_cnt (
        .clk_i      (clk_i),
        .rst_ni     (res_ni),
        .load_i     (accept),
        .load_val_i (amt_i),
        .dec_i      (cnt_dec),
        .cnt_o      (cnt),
        .is_one_o   (cnt_is_one)
    );

    // Next-state logic; abort returns to INIT from every state except INIT itself.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:  state_d = ST_IDLE;
            ST_IDLE: begin
                if (abort_i) begin
                    state_d = ST_INIT;
                end else if (start_i) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (abort_i) begin
                    state_d = ST_INIT;
                end else if (cnt != '0) begin
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (abort_i) begin
                    state_d = ST_INIT;
                end else if (cnt_is_one) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = abort_i ? ST_INIT : ST_IDLE;
            default:  state_d = ST_INIT;
        endcase
    end

    // Command fields are captured only when a command is accepted.
    always_comb begin
        din_d  = din_q;
        dir_d  = dir_q;
        fill_d = fill_q;
        if (accept) begin
            din_d  = din_i;
            dir_d  = dir_i;
            fill_d = fill_i;
        end
    end

    // State and command latches.
    always_ff @(posedge clk_i or negedge res_ni) begin
        if (!res_ni) begin
            state_q <= ST_INIT;
            din_q   <= '0;
            dir_q   <= 1'b0;
            fill_q  <= FILL_ZERO;
        end else begin
            state_q <= state_d;
            din_q   <= din_d;
            dir_q   <= dir_d;
            fill_q  <= fill_d;
        end
    end

    // Fill and outgoing bit follow the live register contents.
    always_comb begin
        fill    = fill_bit(fill_q, dir_q, sr_q_i[W-1], sr_q_i[0], sin_i);
        out_bit = dir_q ? sr_q_i[0] : sr_q_i[W-1];
    end

    assign sr_clr_o   = (state_q == ST_INIT);
    assign sr_pen_o   = (state_q == ST_LOAD);
    assign sr_len_o   = dir_q;
    assign sr_inr_o   = fill;
    assign sr_inl_o   = fill;
    assign sr_din_o   = din_q;
    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = (state_q == ST_DONE);
    assign sout_vld_o = (state_q == ST_SHIFT);
    assign sout_o     = sout_vld_o ? out_bit : 1'b0;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - scoreboard bench for shift_sequencer with a shift register model
module tb_shift_sequencer;

    localparam int W  = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          res_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [W-1:0]  din = '0;
    logic [CW-1:0] amt = '0;
    logic          dir = 1'b0;
    logic [1:0]    fill = 2'b00;
    logic          sin = 1'b0;
    logic [W-1:0]  sr_q = '0;
    logic          sr_clr, sr_pen, sr_len, sr_inr, sr_inl;
    logic [W-1:0]  sr_din;
    logic          busy, done, sout, sout_vld;

    int checks = 0;
    int failures = 0;
    logic exp_q[$];

    shift_sequencer #(.W(W), .CW(CW)) dut (
        .clk_i      (clk),
        .res_ni     (res_n),
        .start_i    (start),
        .abort_i    (abort),
        .din_i      (din),
        .amt_i      (amt),
        .dir_i      (dir),
        .fill_i     (fill),
        .sin_i      (sin),
        .sr_q_i     (sr_q),
        .sr_clr_o   (sr_clr),
        .sr_pen_o   (sr_pen),
        .sr_len_o   (sr_len),
        .sr_inr_o   (sr_inr),
        .sr_inl_o   (sr_inl),
        .sr_din_o   (sr_din),
        .busy_o     (busy),
        .done_o     (done),
        .sout_o     (sout),
        .sout_vld_o (sout_vld)
    );

    always #5 clk = ~clk;

    // Shift register model; it shifts on every cycle the sequencer flags as a shift cycle.
    always @(posedge clk) begin
        if (sr_clr)        sr_q <= '0;
        else if (sr_pen)   sr_q <= sr_din;
        else if (sout_vld) sr_q <= sr_len ? {sr_inl, sr_q[W-1:1]} : {sr_q[W-2:0], sr_inr};
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: expected outgoing bits pushed to the scoreboard, final register value returned.
    task automatic predict(input logic [W-1:0] d, input int n, input logic dr,
                           input logic [1:0] f, input logic s, output logic [W-1:0] fin);
        logic [W-1:0] m;
        logic b, fb;
        m = d;
        for (int i = 0; i < n; i++) begin
            b = dr ? m[0] : m[W-1];
            exp_q.push_back(b);
            case (f)
                2'b00: fb = 1'b0;
                2'b01: fb = 1'b1;
                2'b10: fb = b;
                default: fb = s;
            endcase
            m = dr ? {fb, m[W-1:1]} : {m[W-2:0], fb};
        end
        fin = m;
    endtask

    // Drive one command, compare each shifted bit against the scoreboard, and check timing.
    task automatic run_cmd(input string tag, input logic [W-1:0] d, input int n,
                           input logic dr, input logic [1:0] f, input logic s);
        logic [W-1:0] fin;
        int done_cyc;
        int vld_cnt;
        predict(d, n, dr, f, s, fin);
        @(negedge clk);
        din = d; amt = CW'(n); dir = dr; fill = f; sin = s; start = 1'b1;
        done_cyc = -1;
        vld_cnt = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == 1) check_eq({tag, "_load"}, sr_pen, 1'b1);
            if (sout_vld) begin
                vld_cnt++;
                if (exp_q.size() == 0) check_eq({tag, "_extra_sout"}, 1, 0);
                else check_eq({tag, "_sout"}, sout, exp_q.pop_front());
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
        check_eq({tag, "_done_cycle"}, done_cyc, n + 2);
        check_eq({tag, "_vld_count"}, vld_cnt, n);
        check_eq({tag, "_busy_in_done"}, busy, 1'b1);
        check_eq({tag, "_sb_empty"}, exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
        check_eq({tag, "_reg"}, sr_q, fin);
        check_eq({tag, "_idle"}, {busy, done}, 2'b00);
    endtask

    initial begin
        logic [W-1:0] fin;
        int seen_load;
        int done_cyc;

        // Reset state.
        repeat (2) @(negedge clk);
        check_eq("rst_outs", {sr_clr, busy, sr_pen, done, sout_vld, sout}, 6'b110000);
        check_eq("rst_latches", {sr_len, sr_din, sr_inr}, '0);
        res_n = 1'b1;
        check_eq("init_cycle", {sr_clr, busy}, 2'b11);
        @(negedge clk);
        check_eq("idle_after_init", {sr_clr, busy, done}, 3'b000);
        check_eq("reg_cleared", sr_q, 4'h0);

        run_cmd("c1", 4'b1011, 2, 1'b0, 2'b00, 1'b0);
        run_cmd("c2", 4'b1001, 4, 1'b0, 2'b10, 1'b0);
        run_cmd("c3", 4'hA, 0, 1'b0, 2'b00, 1'b0);
        run_cmd("c4", 4'b0010, 3, 1'b1, 2'b01, 1'b0);
        run_cmd("c5", 4'b0100, 5, 1'b0, 2'b11, 1'b1);
        run_cmd("c6", 4'b1101, 7, 1'b1, 2'b10, 1'b0);
        run_cmd("c7", 4'b0110, 3, 1'b1, 2'b11, 1'b0);

        // Abort in the second shift cycle of an AMT=5 command.
        predict(4'b0110, 5, 1'b0, 2'b00, 1'b0, fin);
        @(negedge clk);
        din = 4'b0110; amt = 3'd5; dir = 1'b0; fill = 2'b00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("ab_load", sr_pen, 1'b1);
        @(negedge clk);
        check_eq("ab_vld1", sout_vld, 1'b1);
        check_eq("ab_sout1", sout, exp_q.pop_front());
        @(negedge clk);
        check_eq("ab_vld2", sout_vld, 1'b1);
        check_eq("ab_sout2", sout, exp_q.pop_front());
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        exp_q.delete();
        check_eq("ab_init", {sr_clr, busy, done, sout_vld}, 4'b1100);
        @(negedge clk);
        check_eq("ab_reg_zero", sr_q, 4'h0);
        check_eq("ab_idle", {busy, done}, 2'b00);

        // START and ABORT together in IDLE go to INIT with no load.
        din = 4'hF; amt = 3'd1; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check_eq("sa_init", {sr_clr, sr_pen}, 2'b10);
        @(negedge clk);
        check_eq("sa_idle", {busy, sr_pen, sr_q}, {2'b00, 4'h0});

        // START held through DONE: one IDLE cycle, then a fresh LOAD.
        din = 4'b0011; amt = 3'd1; dir = 1'b0; fill = 2'b00; start = 1'b1;
        done_cyc = -1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
        check_eq("hold_done_cycle", done_cyc, 3);
        @(negedge clk);
        check_eq("hold_idle", {busy, sr_pen}, 2'b00);
        @(negedge clk);
        check_eq("hold_reload", sr_pen, 1'b1);
        start = 1'b0;
        seen_load = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (done) begin
                seen_load = 1;
                break;
            end
        end
        check_eq("hold_second_done", seen_load, 1);
        @(negedge clk);
        check_eq("hold_final_reg", sr_q, 4'b0110);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
